// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single 16-bit memory port.
// Each granted access holds the memory for LAT cycles, then pulses the owner's valid.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LAT        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_valid,
  output logic [15:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [15:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_valid,
  output logic [15:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  busy
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  localparam logic [3:0] LOAD = 4'(LAT - 1);

  state_t                  state, state_nxt;
  port_t                   last_served, owner;
  logic [3:0]              cnt;
  logic                    lat_wr;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [15:0]             lat_wdata;
  logic                    done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_nxt = state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        // Grants are gated by rst_n so every output reads 0 while reset is held.
        if (rst_n) begin
          if (i_req && d_req) begin
            if (last_served == PORT_I) d_gnt = 1'b1;
            else                       i_gnt = 1'b1;
          end else begin
            i_gnt = i_req;
            d_gnt = d_req;
          end
          if (i_gnt || d_gnt) state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = lat_wr;
        mem_addr  = {lat_addr[ADDR_WIDTH-1:1], 1'b0};
        mem_wdata = lat_wdata;
        if (cnt == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= PORT_I;
      owner       <= PORT_I;
      cnt         <= '0;
      lat_wr      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      i_valid     <= 1'b0;
      d_valid     <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      if (i_gnt || d_gnt) begin
        last_served <= d_gnt ? PORT_D : PORT_I;
        owner       <= d_gnt ? PORT_D : PORT_I;
        lat_addr    <= d_gnt ? d_addr : i_addr;
        lat_wr      <= d_gnt & d_wr;
        lat_wdata   <= d_gnt ? d_wdata : 16'h0000;
        cnt         <= LOAD;
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (done) begin
        if (owner == PORT_D) begin
          d_valid <= 1'b1;
          if (!lat_wr) d_rdata <= mem_rdata;
        end else begin
          i_valid <= 1'b1;
          i_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a LAT=4 instance for the directed scenarios
// and a LAT=1 instance for back-to-back instruction reads.
module tb_mem_arbiter;

  typedef struct packed {
    logic        port_d;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          tests = 0;
  int          fails = 0;

  logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_gnt, i_valid, d_gnt, d_valid, mem_en, mem_wr, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        i_req1 = 1'b0, d_req1 = 1'b0, d_wr1 = 1'b0;
  logic [15:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic        i_gnt1, i_valid1, d_gnt1, d_valid1, mem_en1, mem_wr1, busy1;
  logic [15:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  logic [15:0] mem [0:255];
  exp_t        exp_q[$];
  exp_t        exp1_q[$];
  exp_t        e_mon, e_mon1;
  logic        prev_i, prev_d, prev_i1;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .LAT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_WIDTH(16), .LAT(1)) u_fast (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_valid(i_valid1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Word-addressed memory model: combinational read, write on the clock edge.
  assign mem_rdata  = mem[mem_addr[8:1]];
  assign mem_rdata1 = mem[mem_addr1[8:1]];
  always @(posedge clk) if (mem_en && mem_wr) mem[mem_addr[8:1]] <= mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per valid pulse on either instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_valid && d_valid) check("both_valid", 1, 0);
      if ((i_valid && prev_i) || (d_valid && prev_d)) check("valid_width", 1, 0);
      if (i_valid || d_valid) begin
        if (exp_q.size() == 0) check("unexpected_valid", {i_valid, d_valid}, 0);
        else begin
          e_mon = exp_q.pop_front();
          check("sb_port", {i_valid, d_valid}, {!e_mon.port_d, e_mon.port_d});
          check("sb_data", e_mon.port_d ? d_rdata : i_rdata, e_mon.data);
        end
      end
      if (d_valid1 || (i_valid1 && prev_i1)) check("fast_valid", {d_valid1, i_valid1}, 2'b01);
      if (i_valid1) begin
        if (exp1_q.size() == 0) check("fast_unexpected", 1, 0);
        else begin
          e_mon1 = exp1_q.pop_front();
          check("fast_data", i_rdata1, e_mon1.data);
        end
      end
    end
    prev_i  = i_valid;
    prev_d  = d_valid;
    prev_i1 = i_valid1;
  end

  // Follows one granted access from the edge after gnt through its valid cycle.
  task automatic access(input bit port_d, input logic [15:0] addr_exp,
                        input bit wr_exp, input logic [15:0] wdata_exp);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        if (port_d) d_req = 1'b0;
        else        i_req = 1'b0;
      end
      @(negedge clk);
      check("access", {busy, mem_en, mem_wr, mem_addr, mem_wdata, i_valid, d_valid, i_gnt, d_gnt},
            {1'b1, 1'b1, wr_exp, addr_exp, wdata_exp, 4'b0000});
    end
    @(posedge clk);
    @(negedge clk);
    check("valid_cycle", {busy, mem_en, i_valid, d_valid}, {2'b00, !port_d, port_d});
  endtask

  task automatic start_d(input bit wr, input logic [15:0] addr, input logic [15:0] wdata);
    @(posedge clk); #1;
    d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
    @(negedge clk);
    check("d_gnt", {i_gnt, d_gnt}, 2'b01);
  endtask

  task automatic start_i(input logic [15:0] addr);
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = addr;
    @(negedge clk);
    check("i_gnt", {i_gnt, d_gnt}, 2'b10);
  endtask

  initial begin
    logic [15:0] fast_addr [0:2];
    logic [15:0] fast_data [0:2];
    fast_addr = '{16'h0010, 16'h0022, 16'h0031};
    fast_data = '{16'hBEEF, 16'h1234, 16'hA5A5};
    for (int w = 0; w < 256; w++) mem[w] = '0;
    mem[8'h08] = 16'hBEEF;
    mem[8'h18] = 16'hA5A5;

    // Reset state, with a request pending that must not be granted.
    i_req = 1'b1;
    #1;
    check("reset_outputs", {i_gnt, d_gnt, i_valid, d_valid, busy, mem_en, mem_wr, mem_addr, mem_wdata, i_rdata, d_rdata}, 0);
    repeat (2) @(posedge clk);
    #1 i_req = 1'b0; rst_n = 1'b1;

    // Single instruction read.
    start_i(16'h0010);
    exp_q.push_back('{1'b0, 16'hBEEF});
    access(1'b0, 16'h0010, 1'b0, 16'h0000);

    // Data write then read-back; write leaves d_rdata alone.
    start_d(1'b1, 16'h0022, 16'h1234);
    exp_q.push_back('{1'b1, 16'h0000});
    access(1'b1, 16'h0022, 1'b1, 16'h1234);
    start_d(1'b0, 16'h0022, 16'h0000);
    exp_q.push_back('{1'b1, 16'h1234});
    access(1'b1, 16'h0022, 1'b0, 16'h0000);

    // Odd address is word-aligned on the memory port; d_rdata holds.
    start_i(16'h0031);
    exp_q.push_back('{1'b0, 16'hA5A5});
    access(1'b0, 16'h0030, 1'b0, 16'h0000);
    check("d_rdata_hold", d_rdata, 16'h1234);

    // Reset in cycle 2 of a data read aborts it.
    start_d(1'b0, 16'h0010, 16'h0000);
    @(posedge clk); #1 d_req = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0; i_req = 1'b1;
    #1;
    check("async_reset", {i_gnt, d_gnt, i_valid, d_valid, busy, mem_en, mem_wr, mem_addr, mem_wdata, i_rdata, d_rdata}, 0);
    @(posedge clk); #1 i_req = 1'b0; rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_valid_after_abort", {i_valid, d_valid, busy}, 0);
    end

    // Ties alternate, starting with D after reset; I is granted in D's valid cycle.
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 16'h0010;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0022; d_wdata = 16'h0000;
      @(negedge clk);
      check("tie_d_first", {i_gnt, d_gnt}, 2'b01);
      exp_q.push_back('{1'b1, 16'h1234});
      access(1'b1, 16'h0022, 1'b0, 16'h0000);
      check("tie_i_in_valid", {i_gnt, d_gnt}, 2'b10);
      exp_q.push_back('{1'b0, 16'hBEEF});
      access(1'b0, 16'h0010, 1'b0, 16'h0000);
    end

    // LAT=1: request held, one access every two cycles.
    @(posedge clk); #1;
    i_req1 = 1'b1; i_addr1 = fast_addr[0];
    @(negedge clk);
    check("fast_gnt0", i_gnt1, 1'b1);
    exp1_q.push_back('{1'b0, fast_data[0]});
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (n < 2) i_addr1 = fast_addr[n+1];
      else       i_req1 = 1'b0;
      @(negedge clk);
      check("fast_access", {mem_en1, mem_addr1, i_gnt1, i_valid1},
            {1'b1, fast_addr[n] & 16'hFFFE, 2'b00});
      @(posedge clk);
      @(negedge clk);
      check("fast_valid_gnt", {i_valid1, i_gnt1}, {1'b1, n < 2});
      if (n < 2) exp1_q.push_back('{1'b0, fast_data[n+1]});
    end

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    check("fast_sb_drain", exp1_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: byte-address width of all address ports.
REQ-002 Parameter LAT, default 4: cycles the memory port is held per access; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_req  input  1  instruction-port read request; held until granted.
REQ-006 i_addr  input  ADDR_WIDTH  instruction-port byte address.
REQ-007 i_gnt  output  1  instruction request accepted this cycle.
REQ-008 i_valid  output  1  one-cycle pulse; i_rdata holds the read result.
REQ-009 i_rdata  output  16  instruction read data.
REQ-010 d_req  input  1  data-port request; held until granted.
REQ-011 d_wr  input  1  data-port access type: 1 = write, 0 = read.
REQ-012 d_addr  input  ADDR_WIDTH  data-port byte address.
REQ-013 d_wdata  input  16  data-port write data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_valid  output  1  one-cycle completion pulse for a read or a write.
REQ-016 d_rdata  output  16  data read result.
REQ-017 mem_en, mem_wr  output  1 each  memory enable and write strobe.
REQ-018 mem_addr  output  ADDR_WIDTH  memory byte address.
REQ-019 mem_wdata  output  16  memory write data.
REQ-020 mem_rdata  input  16  combinational memory read data.
REQ-021 busy  output  1  high while the FSM is in ACCESS.

Function
REQ-022 The FSM shall have exactly two states: IDLE and ACCESS.
REQ-023 In IDLE with any request, the block shall assert exactly one gnt combinationally in the same cycle.
- On that edge: latch winner address, wr (0 for I-port) and wdata.
- Load the down-counter with LAT-1.
- Move to ACCESS.
REQ-024 Tie (i_req and d_req both high in IDLE): grant the port not served last; last-served flag updates on every grant.
REQ-025 No gnt shall assert outside IDLE; requests arriving during ACCESS wait; a req dropped before gnt is discarded silently.
REQ-026 In ACCESS the memory port shall be driven from latched values.
- mem_en = 1; mem_wr = latched wr.
- mem_addr = latched address with bit 0 forced to 0.
- mem_wdata = latched wdata.
REQ-027 In IDLE the memory port shall be idle: mem_en, mem_wr, mem_addr and mem_wdata all 0.
REQ-028 ACCESS shall last exactly LAT cycles, with the counter decrementing each cycle.
REQ-029 On the edge ending the cycle where counter = 0:
- Read: sample mem_rdata into the owning port's rdata register.
- Read or write: set the owning port's valid for the next cycle.
- Return to IDLE.
REQ-030 Timing: gnt in cycle 0, ACCESS in cycles 1..LAT, valid in cycle LAT+1 (1-cycle pulse); a new gnt may occur in cycle LAT+1.
REQ-031 Write completion shall pulse d_valid and leave d_rdata unchanged.
REQ-032 Each rdata register shall hold its value until that port's next read completes.
REQ-033 i_valid and d_valid shall never be high together, and neither shall stay high for more than one cycle.

Reset
REQ-034 On rst_n low, immediately and regardless of state, the block shall:
- Enter IDLE and clear the counter.
- Drive all outputs to 0, including rdata registers.
- Set the last-served flag to I, so the first tie goes to D.
REQ-035 Reset during ACCESS shall abort the access with no valid pulse after release; the first edge with rst_n high shall behave as normal IDLE.

Verification
REQ-036 Single I read, LAT=4: i_addr=0x0010, mem word 0x0008=0xBEEF -> i_gnt cycle 0; mem_en high cycles 1-4 with mem_addr=0x0010; i_valid cycle 5 with i_rdata=0xBEEF.
REQ-037 D write then D read: d_wr=1, addr 0x0022, wdata 0x1234 -> mem_wr high 4 cycles, d_valid cycle 5 with d_rdata unchanged; read of 0x0022 -> d_rdata=0x1234.
REQ-038 Tie after reset: both req held -> D granted first, I granted in D's valid cycle; both held again -> D, then I (alternating).
REQ-039 Odd address 0x0031 -> mem_addr=0x0030 throughout ACCESS.
REQ-040 rst_n low in cycle 2 of a D read -> all outputs 0 asynchronously; no d_valid after release; next tie grants D.
REQ-041 LAT=1 back-to-back I reads -> gnt, 1 ACCESS cycle, valid with next gnt in the same cycle; sustained 1 access per 2 cycles.
